rr_arb_mux: RTL and testbench

RR_ARB_MUX -- requirements
Module: rr_arb_mux

---
 rtl/rr_arb_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/rr_arb_mux.sv | 87 ++++++++
 tb/tb_rr_arb_mux.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbitrating mux.
package rr_arb_pkg;

    typedef enum logic [0:0] {IDLE, LOCKED} arb_state_e;

    // Index width for n channels, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter with an optional lock onto one channel.
module rr_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]              req,
    input  logic [idx_width(N)-1:0]   ptr,
    input  logic                      lock_en,
    input  logic [idx_width(N)-1:0]   lck,
    output logic [N-1:0]              gnt,
    output logic [idx_width(N)-1:0]   gnt_idx
);

    localparam int unsigned IW = idx_width(N);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        if (lock_en) begin
            if (req[lck]) begin
                gnt[lck] = 1'b1;
                gnt_idx  = lck;
            end
        end else begin
            // Search upward from the channel after the last one served.
            for (int k = 1; k <= int'(N); k++) begin
                cand = IW'((int'(ptr) + k) % int'(N));
                if (!found && req[cand]) begin
                    found     = 1'b1;
                    gnt[cand] = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-to-1 round-robin mux with a one-beat output register and optional packet locking.
module rr_arb_mux
    import rr_arb_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned N        = 4,
    parameter int unsigned PKT_MODE = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N-1:0]            in_valid,
    input  logic [WIDTH-1:0]        in_data [N],
    input  logic [N-1:0]            in_last,
    output logic [N-1:0]            in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [$clog2(N)-1:0]    out_sel,
    output logic                    out_last,
    input  logic                    out_ready
);

    localparam int unsigned IW = idx_width(N);

    arb_state_e    state_q;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] lck_q;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          slot_free;
    logic          lock_en;
    logic          in_xfer;

    assign slot_free = !out_valid || out_ready;
    assign lock_en   = (PKT_MODE != 0) && (state_q == LOCKED);

    rr_arbiter #(
        .N (N)
    ) u_arbiter (
        .req     (in_valid),
        .ptr     (ptr_q),
        .lock_en (lock_en),
        .lck     (lck_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Grants are already masked by in_valid; gate on slot and reset.
    assign in_ready = (slot_free && reset_n) ? gnt : '0;
    assign in_xfer  = |in_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_last  <= 1'b0;
            ptr_q     <= IW'(N - 1);
            state_q   <= IDLE;
            lck_q     <= '0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[gnt_idx];
            out_sel   <= gnt_idx;
            out_last  <= (PKT_MODE != 0) ? in_last[gnt_idx] : 1'b1;
            ptr_q     <= gnt_idx;
            if (PKT_MODE != 0) begin
                unique case (state_q)
                    IDLE: begin
                        if (!in_last[gnt_idx]) begin
                            state_q <= LOCKED;
                            lck_q   <= gnt_idx;
                        end
                    end
                    LOCKED: begin
                        if (in_last[gnt_idx]) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench: one beat-mode and one packet-mode instance sharing clock and reset.
module tb_rr_arb_mux;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] a_valid, a_last, a_in_ready;
    logic [7:0] a_data [4];
    logic       a_out_valid, a_out_last, a_ready;
    logic [7:0] a_out_data;
    logic [1:0] a_out_sel;

    logic [3:0] b_valid, b_last, b_in_ready;
    logic [7:0] b_data [4];
    logic       b_out_valid, b_out_last, b_ready;
    logic [7:0] b_out_data;
    logic [1:0] b_out_sel;

    rr_arb_mux #(.WIDTH(8), .N(4), .PKT_MODE(0)) u_beat (
        .clk(clk), .reset_n(reset_n), .in_valid(a_valid), .in_data(a_data),
        .in_last(a_last), .in_ready(a_in_ready), .out_valid(a_out_valid),
        .out_data(a_out_data), .out_sel(a_out_sel), .out_last(a_out_last),
        .out_ready(a_ready)
    );

    rr_arb_mux #(.WIDTH(8), .N(4), .PKT_MODE(1)) u_pkt (
        .clk(clk), .reset_n(reset_n), .in_valid(b_valid), .in_data(b_data),
        .in_last(b_last), .in_ready(b_in_ready), .out_valid(b_out_valid),
        .out_data(b_out_data), .out_sel(b_out_sel), .out_last(b_out_last),
        .out_ready(b_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard entries: {sel, data, last}
    logic [10:0] qa [$];
    logic [10:0] qb [$];

    always @(posedge clk) begin
        if (mon_en) begin
            logic [10:0] exp;
            chk("a_onehot0", 32'($onehot0(a_in_ready)), 32'd1);
            chk("a_sb_level", 32'(qa.size()), 32'(a_out_valid));
            if (!reset_n) begin
                chk("a_rst_ready", 32'(a_in_ready), 32'd0);
                qa.delete();
            end else begin
                if (a_out_valid && a_ready) begin
                    exp = (qa.size() > 0) ? qa.pop_front() : 'x;
                    chk("a_sb_beat", 32'({a_out_sel, a_out_data, a_out_last}), 32'(exp));
                end
                for (int i = 0; i < 4; i++)
                    if (a_valid[i] && a_in_ready[i]) qa.push_back({2'(i), a_data[i], 1'b1});
            end
        end
    end

    always @(posedge clk) begin
        if (mon_en) begin
            logic [10:0] exp;
            chk("b_onehot0", 32'($onehot0(b_in_ready)), 32'd1);
            chk("b_sb_level", 32'(qb.size()), 32'(b_out_valid));
            if (!reset_n) begin
                chk("b_rst_ready", 32'(b_in_ready), 32'd0);
                qb.delete();
            end else begin
                if (b_out_valid && b_ready) begin
                    exp = (qb.size() > 0) ? qb.pop_front() : 'x;
                    chk("b_sb_beat", 32'({b_out_sel, b_out_data, b_out_last}), 32'(exp));
                end
                for (int i = 0; i < 4; i++)
                    if (b_valid[i] && b_in_ready[i]) qb.push_back({2'(i), b_data[i], b_last[i]});
            end
        end
    end

    initial begin
        a_valid = 4'b1111; a_last = 4'b0000; a_ready = 1'b1;
        a_data[0] = 8'h10; a_data[1] = 8'h11; a_data[2] = 8'h12; a_data[3] = 8'h13;
        b_valid = 4'b1111; b_last = 4'b0000; b_ready = 1'b1;
        for (int i = 0; i < 4; i++) b_data[i] = 8'h00;

        // Reset with requests pending: nothing may be granted.
        tick();
        tick();
        mon_en = 1'b1;
        chk("rst_a_ready", 32'(a_in_ready), 32'd0);
        chk("rst_b_ready", 32'(b_in_ready), 32'd0);
        chk("rst_a_valid", 32'(a_out_valid), 32'd0);
        chk("rst_a_data", 32'(a_out_data), 32'd0);
        chk("rst_a_sel", 32'(a_out_sel), 32'd0);
        chk("rst_a_last", 32'(a_out_last), 32'd0);
        chk("rst_b_valid", 32'(b_out_valid), 32'd0);
        chk("rst_b_last", 32'(b_out_last), 32'd0);

        // Beat mode, all channels valid: 0,1,2,3,0.
        reset_n = 1'b1;
        b_valid = 4'b0000;
        #1;
        chk("rr_first_ready", 32'(a_in_ready), 32'b0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_valid", 32'(a_out_valid), 32'd1);
            chk("rr_sel", 32'(a_out_sel), 32'(i % 4));
            chk("rr_data", 32'(a_out_data), 32'(8'h10 + i % 4));
            chk("rr_last", 32'(a_out_last), 32'd1);
            #1;
            chk("rr_ready", 32'(a_in_ready), 32'(1 << ((i + 1) % 4)));
        end

        // Beat mode stall: ch2 holds A5 while out_ready is low.
        a_valid = 4'b0100; a_data[2] = 8'hA5;
        #1;
        chk("stall_pre_ready", 32'(a_in_ready), 32'b0100);
        tick();
        a_ready = 1'b0;
        #1;
        chk("stall_load_ready", 32'(a_in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", 32'(a_out_valid), 32'd1);
            chk("stall_data", 32'(a_out_data), 32'hA5);
            chk("stall_sel", 32'(a_out_sel), 32'd2);
            #1;
            chk("stall_ready", 32'(a_in_ready), 32'd0);
        end
        a_ready = 1'b1; a_valid = 4'b0000;
        tick();
        chk("stall_drain", 32'(a_out_valid), 32'd0);

        // Packet mode: one single-beat packet from ch0 moves ptr to 0.
        b_valid = 4'b0001; b_last = 4'b0001; b_data[0] = 8'h01;
        #1;
        chk("pkt_pre_ready", 32'(b_in_ready), 32'b0001);
        tick();
        chk("pkt_pre_sel", 32'(b_out_sel), 32'd0);
        chk("pkt_pre_last", 32'(b_out_last), 32'd1);
        // ch1 three-beat packet while ch0 and ch3 compete.
        b_valid = 4'b1011; b_last = 4'b1001;
        b_data[0] = 8'h02; b_data[1] = 8'h11; b_data[3] = 8'h31;
        #1;
        chk("pkt_b1_ready", 32'(b_in_ready), 32'b0010);
        tick();
        chk("pkt_b1_sel", 32'(b_out_sel), 32'd1);
        chk("pkt_b1_last", 32'(b_out_last), 32'd0);
        b_data[1] = 8'h12;
        #1;
        chk("pkt_b2_ready", 32'(b_in_ready), 32'b0010);
        tick();
        chk("pkt_b2_sel", 32'(b_out_sel), 32'd1);
        chk("pkt_b2_data", 32'(b_out_data), 32'h12);
        b_data[1] = 8'h13; b_last = 4'b1011;
        #1;
        chk("pkt_b3_ready", 32'(b_in_ready), 32'b0010);
        tick();
        chk("pkt_b3_sel", 32'(b_out_sel), 32'd1);
        chk("pkt_b3_last", 32'(b_out_last), 32'd1);
        b_valid = 4'b1001;
        #1;
        chk("pkt_ch3_ready", 32'(b_in_ready), 32'b1000);
        tick();
        chk("pkt_ch3_sel", 32'(b_out_sel), 32'd3);
        chk("pkt_ch3_data", 32'(b_out_data), 32'h31);
        #1;
        chk("pkt_ch0_ready", 32'(b_in_ready), 32'b0001);
        tick();
        chk("pkt_ch0_sel", 32'(b_out_sel), 32'd0);
        chk("pkt_ch0_data", 32'(b_out_data), 32'h02);

        // Locked channel goes idle for two cycles: ch0 must not be granted.
        b_valid = 4'b0011; b_last = 4'b0001; b_data[0] = 8'h05; b_data[1] = 8'h21;
        #1;
        chk("gap_first_ready", 32'(b_in_ready), 32'b0010);
        tick();
        chk("gap_first_sel", 32'(b_out_sel), 32'd1);
        b_valid = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("gap_ready", 32'(b_in_ready), 32'd0);
            tick();
            chk("gap_valid", 32'(b_out_valid), 32'd0);
        end
        b_valid = 4'b0011; b_last = 4'b0011; b_data[1] = 8'h22;
        #1;
        chk("gap_resume_ready", 32'(b_in_ready), 32'b0010);
        tick();
        chk("gap_resume_sel", 32'(b_out_sel), 32'd1);
        chk("gap_resume_data", 32'(b_out_data), 32'h22);
        chk("gap_resume_last", 32'(b_out_last), 32'd1);

        // Reset mid-packet with a held beat.
        b_valid = 4'b0100; b_last = 4'b0000; b_data[2] = 8'h41;
        #1;
        chk("mid_ready", 32'(b_in_ready), 32'b0100);
        tick();
        chk("mid_sel", 32'(b_out_sel), 32'd2);
        b_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(b_in_ready), 32'd0);
        tick();
        chk("mid_rst_valid", 32'(b_out_valid), 32'd0);
        chk("mid_rst_data", 32'(b_out_data), 32'd0);
        chk("mid_rst_sel", 32'(b_out_sel), 32'd0);
        reset_n = 1'b1; b_ready = 1'b1;
        b_valid = 4'b1111; b_last = 4'b1111;
        for (int i = 0; i < 4; i++) b_data[i] = 8'h50 + 8'(i);
        #1;
        chk("post_rst_ready", 32'(b_in_ready), 32'b0001);
        tick();
        chk("post_rst_sel", 32'(b_out_sel), 32'd0);
        chk("post_rst_data", 32'(b_out_data), 32'h50);
        #1;
        chk("post_rst_unlocked", 32'(b_in_ready), 32'b0010);
        b_valid = 4'b0000;
        tick();
        tick();
        chk("end_b_valid", 32'(b_out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
